// File: rtl/id_stage.sv
// rtl/id_stage.sv - ARM-subset instruction decode stage with register file and ID/EX register (optional WB_BYPASS_EN write-through read bypass)
module id_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic [31:0] instruction_in,
   input  logic [3:0]  status,
   input  logic        hazard,
   input  logic        flush,
   input  logic        wb_wb_en,
   input  logic [3:0]  wb_dest,
   input  logic [31:0] wb_value,
   output logic [3:0]  src1,
   output logic [3:0]  src2,
   output logic        two_src,
   output logic [31:0] pc_out,
   output logic [31:0] val_rn,
   output logic [31:0] val_rm,
   output logic [3:0]  exe_cmd,
   output logic        mem_r_en,
   output logic        mem_w_en,
   output logic        wb_en,
   output logic        b,
   output logic        s,
   output logic        imm,
   output logic [11:0] shift_operand,
   output logic [23:0] signed_imm_24,
   output logic [3:0]  dest
);

   // Instruction fields
   logic [3:0] condField;
   logic [1:0] modeField;
   logic       immBit;
   logic [3:0] opcodeField;
   logic       sBit;
   logic [3:0] rnIdx;
   logic [3:0] rdIdx;
   logic [3:0] rmIdx;
   logic       isStore;

   assign condField   = instruction_in[31:28];
   assign modeField   = instruction_in[27:26];
   assign immBit      = instruction_in[25];
   assign opcodeField = instruction_in[24:21];
   assign sBit        = instruction_in[20];
   assign rnIdx       = instruction_in[19:16];
   assign rdIdx       = instruction_in[15:12];
   assign rmIdx       = instruction_in[3:0];
   assign isStore     = (modeField == 2'b01) && !sBit;

   // Hazard-unit source indices; a store reads Rd as its data operand
   assign src1    = rnIdx;
   assign src2    = isStore ? rdIdx : rmIdx;
   assign two_src = !immBit || isStore;

   // Register file R0-R14; index 15 is not backed by storage
   logic [31:0] regFile [0:14];

   // Write-back port: writes to index 15 are dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 15; i++) begin
            regFile[i] <= '0;
         end
      end else if (wb_wb_en && (wb_dest != 4'hF)) begin
         regFile[wb_dest] <= wb_value;
      end
   end

   // Rn read port, index 15 reads as zero
   logic [31:0] rnValue;
   always_comb begin
      rnValue = '0;
      if (src1 != 4'hF) begin
         rnValue = regFile[src1];
`ifdef WB_BYPASS_EN
         if (wb_wb_en && (wb_dest == src1)) begin
            rnValue = wb_value;
         end
`endif
      end
   end

   // Rm / store-data read port, index 15 reads as zero
   logic [31:0] rmValue;
   always_comb begin
      rmValue = '0;
      if (src2 != 4'hF) begin
         rmValue = regFile[src2];
`ifdef WB_BYPASS_EN
         if (wb_wb_en && (wb_dest == src2)) begin
            rmValue = wb_value;
         end
`endif
      end
   end

   // Condition evaluation against NZCV; code 1111 never executes
   logic flagN, flagZ, flagC, flagV;
   logic condPass;
   assign {flagN, flagZ, flagC, flagV} = status;

   always_comb begin
      condPass = 1'b0;
      case (condField)
         4'b0000: condPass = flagZ;
         4'b0001: condPass = !flagZ;
         4'b0010: condPass = flagC;
         4'b0011: condPass = !flagC;
         4'b0100: condPass = flagN;
         4'b0101: condPass = !flagN;
         4'b0110: condPass = flagV;
         4'b0111: condPass = !flagV;
         4'b1000: condPass = flagC && !flagZ;
         4'b1001: condPass = !flagC || flagZ;
         4'b1010: condPass = (flagN == flagV);
         4'b1011: condPass = (flagN != flagV);
         4'b1100: condPass = !flagZ && (flagN == flagV);
         4'b1101: condPass = flagZ || (flagN != flagV);
         4'b1110: condPass = 1'b1;
         default: condPass = 1'b0;
      endcase
   end

   // Control decode from mode/opcode/S
   logic [3:0] decExeCmd;
   logic       decMemREn, decMemWEn, decWbEn, decB, decS;

   always_comb begin
      decExeCmd = 4'b0000;
      decMemREn = 1'b0;
      decMemWEn = 1'b0;
      decWbEn   = 1'b0;
      decB      = 1'b0;
      decS      = 1'b0;
      case (modeField)
         2'b00: begin
            decWbEn = 1'b1;
            decS    = sBit;
            case (opcodeField)
               4'b1101: decExeCmd = 4'b0001;
               4'b1111: decExeCmd = 4'b1001;
               4'b0100: decExeCmd = 4'b0010;
               4'b0101: decExeCmd = 4'b0011;
               4'b0010: decExeCmd = 4'b0100;
               4'b0110: decExeCmd = 4'b0101;
               4'b0000: decExeCmd = 4'b0110;
               4'b1100: decExeCmd = 4'b0111;
               4'b0001: decExeCmd = 4'b1000;
               4'b1010: begin
                  decExeCmd = 4'b0100;
                  decWbEn   = 1'b0;
               end
               4'b1000: begin
                  decExeCmd = 4'b0110;
                  decWbEn   = 1'b0;
               end
               default: begin
                  decWbEn = 1'b0;
                  decS    = 1'b0;
               end
            endcase
         end
         2'b01: begin
            decExeCmd = 4'b0010;
            if (sBit) begin
               decMemREn = 1'b1;
               decWbEn   = 1'b1;
            end else begin
               decMemWEn = 1'b1;
            end
         end
         2'b10: begin
            decB = 1'b1;
         end
         default: begin
            decB = 1'b0;
         end
      endcase
   end

   // Bubble: a failed condition or a hazard kills control but keeps data
   logic keepCtrl;
   assign keepCtrl = condPass && !hazard;

   // ID/EX register: reset > flush > capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_out        <= '0;
         val_rn        <= '0;
         val_rm        <= '0;
         exe_cmd       <= '0;
         mem_r_en      <= 1'b0;
         mem_w_en      <= 1'b0;
         wb_en         <= 1'b0;
         b             <= 1'b0;
         s             <= 1'b0;
         imm           <= 1'b0;
         shift_operand <= '0;
         signed_imm_24 <= '0;
         dest          <= '0;
      end else if (flush) begin
         pc_out        <= '0;
         val_rn        <= '0;
         val_rm        <= '0;
         exe_cmd       <= '0;
         mem_r_en      <= 1'b0;
         mem_w_en      <= 1'b0;
         wb_en         <= 1'b0;
         b             <= 1'b0;
         s             <= 1'b0;
         imm           <= 1'b0;
         shift_operand <= '0;
         signed_imm_24 <= '0;
         dest          <= '0;
      end else begin
         pc_out        <= pc_in;
         val_rn        <= rnValue;
         val_rm        <= rmValue;
         exe_cmd       <= keepCtrl ? decExeCmd : 4'b0000;
         mem_r_en      <= keepCtrl && decMemREn;
         mem_w_en      <= keepCtrl && decMemWEn;
         wb_en         <= keepCtrl && decWbEn;
         b             <= keepCtrl && decB;
         s             <= keepCtrl && decS;
         imm           <= immBit;
         shift_operand <= instruction_in[11:0];
         signed_imm_24 <= instruction_in[23:0];
         dest          <= rdIdx;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic [31:0] instruction_in;
   logic [3:0]  status;
   logic        hazard;
   logic        flush;
   logic        wb_wb_en;
   logic [3:0]  wb_dest;
   logic [31:0] wb_value;
   logic [3:0]  src1, src2;
   logic        two_src;
   logic [31:0] pc_out, val_rn, val_rm;
   logic [3:0]  exe_cmd;
   logic        mem_r_en, mem_w_en, wb_en, b, s, imm;
   logic [11:0] shift_operand;
   logic [23:0] signed_imm_24;
   logic [3:0]  dest;

   int vectors = 0;
   int miscompares = 0;

   logic [145:0] allOut;
   assign allOut = {pc_out, val_rn, val_rm, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, imm,
                    shift_operand, signed_imm_24, dest};

   id_stage dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .instruction_in(instruction_in), .status(status),
      .hazard(hazard), .flush(flush), .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
      .src1(src1), .src2(src2), .two_src(two_src), .pc_out(pc_out), .val_rn(val_rn), .val_rm(val_rm),
      .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en), .b(b), .s(s),
      .imm(imm), .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .dest(dest)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wbWrite(input logic [3:0] d, input logic [31:0] v);
      wb_wb_en = 1'b1;
      wb_dest = d;
      wb_value = v;
      instruction_in = 32'hF000_0000;
      step();
      wb_wb_en = 1'b0;
   endtask

   task automatic test_reset;
      vectors++;
      if (allOut !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h, expected 0", allOut);
      end
   endtask

   task automatic test_add;
      wbWrite(4'd1, 32'd5);
      wbWrite(4'd2, 32'd7);
      status = 4'b0000;
      pc_in = 32'd100;
      instruction_in = 32'hE081_3002;
      #1;
      vectors++;
      if ({src1, src2, two_src} !== {4'd1, 4'd2, 1'b1}) begin
         miscompares++;
         $display("FAIL add_srcs: got %h/%h/%b, expected 1/2/1", src1, src2, two_src);
      end
      step();
      vectors++;
      if ({exe_cmd, wb_en, mem_r_en, mem_w_en, b, dest} !== {4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3}) begin
         miscompares++;
         $display("FAIL add_ctrl: got cmd=%b wb=%b mr=%b mw=%b b=%b dest=%0d, expected 0010 1 0 0 0 3",
                  exe_cmd, wb_en, mem_r_en, mem_w_en, b, dest);
      end
      vectors++;
      if ({val_rn, val_rm, pc_out} !== {32'd5, 32'd7, 32'd100}) begin
         miscompares++;
         $display("FAIL add_data: got rn=%0d rm=%0d pc=%0d, expected 5 7 100", val_rn, val_rm, pc_out);
      end
   endtask

   task automatic test_condition;
      instruction_in = 32'h0081_3002;
      status = 4'b0000;
      step();
      vectors++;
      if ({exe_cmd, wb_en, dest, val_rn} !== {4'b0000, 1'b0, 4'd3, 32'd5}) begin
         miscompares++;
         $display("FAIL eq_fail: got cmd=%b wb=%b dest=%0d rn=%0d, expected 0000 0 3 5", exe_cmd, wb_en, dest, val_rn);
      end
      status = 4'b0100;
      step();
      vectors++;
      if ({exe_cmd, wb_en} !== {4'b0010, 1'b1}) begin
         miscompares++;
         $display("FAIL eq_pass: got cmd=%b wb=%b, expected 0010 1", exe_cmd, wb_en);
      end
      instruction_in = 32'hC081_3002;
      status = 4'b1000;
      step();
      vectors++;
      if (wb_en !== 1'b0) begin
         miscompares++;
         $display("FAIL gt_fail: got wb=%b, expected 0", wb_en);
      end
      status = 4'b1001;
      step();
      vectors++;
      if (wb_en !== 1'b1) begin
         miscompares++;
         $display("FAIL gt_pass: got wb=%b, expected 1", wb_en);
      end
      instruction_in = 32'hF081_3002;
      status = 4'b0000;
      step();
      vectors++;
      if (wb_en !== 1'b0) begin
         miscompares++;
         $display("FAIL nv_cond: got wb=%b, expected 0", wb_en);
      end
   endtask

   task automatic test_hazard;
      instruction_in = 32'hE081_3002;
      hazard = 1'b1;
      step();
      hazard = 1'b0;
      vectors++;
      if ({exe_cmd, wb_en, val_rm, dest} !== {4'b0000, 1'b0, 32'd7, 4'd3}) begin
         miscompares++;
         $display("FAIL hazard_bubble: got cmd=%b wb=%b rm=%0d dest=%0d, expected 0000 0 7 3", exe_cmd, wb_en, val_rm, dest);
      end
   endtask

   task automatic test_dataproc;
      instruction_in = 32'hE3A0_1005;
      #1;
      vectors++;
      if (two_src !== 1'b0) begin
         miscompares++;
         $display("FAIL mov_two_src: got %b, expected 0", two_src);
      end
      step();
      vectors++;
      if ({exe_cmd, imm, wb_en, shift_operand, dest} !== {4'b0001, 1'b1, 1'b1, 12'h005, 4'd1}) begin
         miscompares++;
         $display("FAIL mov_imm: got cmd=%b imm=%b wb=%b op=%h dest=%0d, expected 0001 1 1 005 1",
                  exe_cmd, imm, wb_en, shift_operand, dest);
      end
      instruction_in = 32'hE151_0002;
      step();
      vectors++;
      if ({exe_cmd, wb_en, s} !== {4'b0100, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL cmp: got cmd=%b wb=%b s=%b, expected 0100 0 1", exe_cmd, wb_en, s);
      end
      instruction_in = 32'hE061_3002;
      step();
      vectors++;
      if ({exe_cmd, wb_en, s} !== {4'b0000, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL undef_op: got cmd=%b wb=%b s=%b, expected 0000 0 0", exe_cmd, wb_en, s);
      end
   endtask

   task automatic test_memory;
      instruction_in = 32'hE581_2000;
      #1;
      vectors++;
      if ({src1, src2, two_src} !== {4'd1, 4'd2, 1'b1}) begin
         miscompares++;
         $display("FAIL str_srcs: got %h/%h/%b, expected 1/2/1", src1, src2, two_src);
      end
      step();
      vectors++;
      if ({mem_w_en, mem_r_en, exe_cmd, wb_en, val_rm} !== {1'b1, 1'b0, 4'b0010, 1'b0, 32'd7}) begin
         miscompares++;
         $display("FAIL str_ctrl: got mw=%b mr=%b cmd=%b wb=%b rm=%0d, expected 1 0 0010 0 7",
                  mem_w_en, mem_r_en, exe_cmd, wb_en, val_rm);
      end
      instruction_in = 32'hE591_2000;
      #1;
      vectors++;
      if ({src2, two_src} !== {4'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL ldr_srcs: got %h/%b, expected 0/1", src2, two_src);
      end
      step();
      vectors++;
      if ({mem_r_en, mem_w_en, wb_en, exe_cmd} !== {1'b1, 1'b0, 1'b1, 4'b0010}) begin
         miscompares++;
         $display("FAIL ldr_ctrl: got mr=%b mw=%b wb=%b cmd=%b, expected 1 0 1 0010", mem_r_en, mem_w_en, wb_en, exe_cmd);
      end
   endtask

   task automatic test_bypass;
      logic [31:0] expRn;
`ifdef WB_BYPASS_EN
      expRn = 32'd9;
`else
      expRn = 32'd5;
`endif
      wb_wb_en = 1'b1;
      wb_dest = 4'd1;
      wb_value = 32'd9;
      instruction_in = 32'hE081_3002;
      step();
      wb_wb_en = 1'b0;
      vectors++;
      if (val_rn !== expRn) begin
         miscompares++;
         $display("FAIL same_cycle_rw: got %0d, expected %0d", val_rn, expRn);
      end
      step();
      vectors++;
      if (val_rn !== 32'd9) begin
         miscompares++;
         $display("FAIL after_write: got %0d, expected 9", val_rn);
      end
      wb_wb_en = 1'b1;
      wb_dest = 4'hF;
      wb_value = 32'hDEAD;
      instruction_in = 32'hE08F_3002;
      step();
      wb_wb_en = 1'b0;
      step();
      vectors++;
      if (val_rn !== 32'd0) begin
         miscompares++;
         $display("FAIL r15_read: got %h, expected 0", val_rn);
      end
   endtask

   task automatic test_back_to_back;
      wbWrite(4'd4, 32'd1);
      wbWrite(4'd4, 32'd2);
      instruction_in = 32'hE084_3002;
      step();
      vectors++;
      if (val_rn !== 32'd2) begin
         miscompares++;
         $display("FAIL b2b_write: got %0d, expected 2", val_rn);
      end
   endtask

   task automatic test_branch;
      pc_in = 32'd200;
      instruction_in = 32'hEA00_0004;
      step();
      vectors++;
      if ({b, signed_imm_24, exe_cmd, wb_en, pc_out} !== {1'b1, 24'h000004, 4'b0000, 1'b0, 32'd200}) begin
         miscompares++;
         $display("FAIL branch: got b=%b imm=%h cmd=%b wb=%b pc=%0d, expected 1 000004 0000 0 200",
                  b, signed_imm_24, exe_cmd, wb_en, pc_out);
      end
      flush = 1'b1;
      hazard = 1'b1;
      step();
      flush = 1'b0;
      hazard = 1'b0;
      vectors++;
      if (allOut !== '0) begin
         miscompares++;
         $display("FAIL flush_hazard: got %h, expected 0", allOut);
      end
   endtask

   task automatic test_midrun_reset;
      wbWrite(4'd3, 32'h33);
      instruction_in = 32'hE081_3002;
      step();
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (allOut !== '0) begin
         miscompares++;
         $display("FAIL async_reset: got %h, expected 0", allOut);
      end
      #2 rst = 1'b0;
      instruction_in = 32'hE083_3003;
      step();
      vectors++;
      if ({val_rn, val_rm, exe_cmd, wb_en} !== {32'd0, 32'd0, 4'b0010, 1'b1}) begin
         miscompares++;
         $display("FAIL post_reset: got rn=%h rm=%h cmd=%b wb=%b, expected 0 0 0010 1", val_rn, val_rm, exe_cmd, wb_en);
      end
   endtask

   initial begin
      rst = 1'b1;
      pc_in = '0;
      instruction_in = '0;
      status = '0;
      hazard = 1'b0;
      flush = 1'b0;
      wb_wb_en = 1'b0;
      wb_dest = '0;
      wb_value = '0;
      step();
      step();
      test_reset();
      rst = 1'b0;
      test_add();
      test_condition();
      test_hazard();
      test_dataproc();
      test_memory();
      test_bypass();
      test_back_to_back();
      test_branch();
      test_midrun_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage ARM-subset pipeline. It sits between the IF/ID pipeline register and the execute stage. Each cycle it decodes the instruction held in IF/ID, reads operands from a 15-entry register file that the write-back stage updates, and evaluates the condition field against the NZCV flags. It also exposes source indices to the hazard unit and captures everything in an internal ID/EX register that supports flush and bubble insertion.

## Interface
- No parameters; widths fixed (32-bit datapath, 4-bit register index).
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pc_in  in  32  PC from IF/ID
- instruction_in  in  32  instruction from IF/ID
- status  in  4  NZCV flags {N,Z,C,V} from status register
- hazard  in  1  hazard unit: convert current decode to bubble
- flush  in  1  branch taken in EX: clear ID/EX on next edge
- wb_wb_en  in  1  write-back enable
- wb_dest  in  4  write-back register index
- wb_value  in  32  write-back data
- src1  out  4  Rn = instruction_in[19:16], combinational
- src2  out  4  instruction_in[15:12] if store, else instruction_in[3:0], combinational
- two_src  out  1  ~I | store, combinational
- pc_out, val_rn, val_rm  out  32 each  registered PC and operand values
- exe_cmd  out  4  registered ALU command
- mem_r_en, mem_w_en, wb_en, b, s, imm  out  1 each  registered control
- shift_operand  out  12  registered instruction[11:0]
- signed_imm_24  out  24  registered instruction[23:0]
- dest  out  4  registered Rd

## Operation
- Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12].
- Mode 00, data-processing. exe_cmd mapping: MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000, CMP 1010→0100, TST 1000→0110.
  - wb_en=1 except for CMP/TST.
  - s=S.
  - Undefined opcodes decode to all-zero control.
- Mode 01, memory. exe_cmd=0010.
  - S=1 (LDR): mem_r_en=1, wb_en=1.
  - S=0 (STR): mem_w_en=1.
- Mode 10, branch: b=1, other control 0.
- Condition check: EQ/NE/CS/CC/MI/PL/VS/VC/HI/LS/GE/LT/GT/LE/AL per ARM, using status. Code 1111 is treated as never.
- Bubble rule: if condition fails OR hazard=1, the control fields (exe_cmd, mem_r_en, mem_w_en, wb_en, b, s) captured into ID/EX are 0. Data fields are captured unchanged.
- Register file: R0–R14.
  - Write at rising edge when wb_wb_en=1 and wb_dest≠4'hF. Writes to index 15 are ignored.
  - Reads are combinational. Reading index 15 returns 32'h0.
- ID/EX priority per edge: rst > flush (all outputs 0) > normal capture. hazard never blocks capture; it only zeroes control.

## Timing
- Decode latency is 1 cycle: inputs present before edge k appear on registered outputs after edge k.
- src1, src2 and two_src are valid combinationally in the same cycle as instruction_in.
- The register-file write takes effect at the same edge as the ID/EX capture. Same-cycle read/write behaviour depends on the Configuration section.
- Reset: asserting rst clears all registered outputs to 0 and all R0–R14 to 0 immediately, without waiting for clk. Deasserting rst mid-stream causes the next edge to capture normally.
- flush and hazard both high: flush wins and all outputs become 0.
- Back-to-back writes to the same register: the last edge wins.

## Configuration
- WB_BYPASS_EN defined: if wb_wb_en=1 and wb_dest matches a read index (not 15), the read returns wb_value in the same cycle. This is write-through, so a decode in the same cycle as write-back of that register sees the new value.
- WB_BYPASS_EN undefined: reads return the stored value. The hazard unit must stall one extra cycle for this case.

## Test plan
- Reset: rst pulse mid-run → all outputs 0 immediately; reading R3 returns 0.
- ADD with Z flag irrelevant (AL): after writing R1=5, R2=7, decode `E0813002` (ADD R3,R1,R2) → next edge: exe_cmd=0010, wb_en=1, val_rn=5, val_rm=7, dest=3.
- Condition fail: status Z=0, decode `00813002` (ADDEQ) → exe_cmd=0, wb_en=0, dest=3.
- STR src2: `E5812000` → src2=2, two_src=1; next edge mem_w_en=1, exe_cmd=0010, wb_en=0.
- Same-cycle write/read: wb writes R1=9 while decoding an instruction that reads R1 → val_rn=9 with WB_BYPASS_EN defined, old value without it.
- flush+hazard together during a branch `EA000004` → all outputs 0. Branch alone → b=1, signed_imm_24=24'h000004.
